// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path: default clock/baud pair and counter sizing.
package uart_rx_pkg;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DEF_BAUD     = 115_200;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle (high) level.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready output holding register, frame error and overrun pulses.
// state     | meaning
// IDLE      | line high, waiting for a start edge
// START     | qualifying the start bit at its centre
// DATA      | sampling 8 data bits, LSB first
// STOP      | sampling the stop bit
// WAIT_IDLE | bad stop seen, waiting for the line to return high
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF         = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF_TC = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             rx_s;
    logic             tc_half, tc_bit, byte_done;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign tc_half   = (cnt_q == CNT_HALF_TC);
    assign tc_bit    = (cnt_q == CNT_BIT_TC);
    assign byte_done = (state_q == S_STOP) && tc_bit && rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (!rx_s) state_d = S_START;
            S_START:     if (tc_half) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA:      if (tc_bit && (idx_q == 3'd7)) state_d = S_STOP;
            S_STOP:      if (tc_bit) state_d = rx_s ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (rx_s) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = '0;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = valid_q && !ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        case (state_q)
            S_START: begin
                cnt_d = tc_half ? '0 : cnt_q + 1'b1;
                if (tc_half) idx_d = '0;
            end
            S_DATA: begin
                cnt_d = tc_bit ? '0 : cnt_q + 1'b1;
                if (tc_bit) begin
                    shreg_d = {rx_s, shreg_q[7:1]};
                    idx_d   = (idx_q == 3'd7) ? 3'd0 : idx_q + 3'd1;
                end
            end
            S_STOP: begin
                cnt_d = tc_bit ? '0 : cnt_q + 1'b1;
                if (tc_bit && !rx_s) frame_err_d = 1'b1;
            end
            default: cnt_d = '0;
        endcase
        // a pending byte that is not being consumed this cycle wins over the new one
        if (byte_done) begin
            if (!valid_q || ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: stimulus pushes expected bytes/events, a monitor pops on handshake.
module tb_uart_rx;

    localparam int CLK_FREQ = 10_000_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int HALF     = CPB / 2;
    localparam int LATENCY  = 2 + HALF + 9 * CPB + 1;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       rx    = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, overrun, busy;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0;
    longint     cyc = 0, t_valid = 0;
    logic       valid_prev = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) begin
                if (exp_q.size() == 0) check("valid_with_empty_queue", longint'(exp_q.size()), 1);
                else check("data", longint'(data), longint'(exp_q.pop_front()));
            end
            if (valid && !valid_prev) t_valid = cyc;
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
        end
        valid_prev = valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int len);
        rx = 1'b0;
        wait_cycles(len);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(len);
        end
        rx = stop_bit;
        wait_cycles(len);
    endtask

    // reference: a good frame yields the byte, or an overrun if a byte is still pending; a bad stop yields frame_err
    task automatic xmit(input logic [7:0] b, input logic stop_bit, input int len, input logic pending);
        if (!stop_bit) exp_fe++;
        else if (pending) exp_ov++;
        else exp_q.push_back(b);
        send_frame(b, stop_bit, len);
    endtask

    initial begin
        longint t0;
        logic [7:0] rb;
        int len, gap;
        logic bad;

        wait_cycles(5);
        check("rst_data", longint'(data), 0);
        check("rst_valid", longint'(valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_frame_err", longint'(frame_err), 0);
        check("rst_overrun", longint'(overrun), 0);
        rst = 1'b0;
        wait_cycles(10);

        t0 = cyc;
        xmit(8'h55, 1'b1, CPB, 1'b0);
        rx = 1'b1;
        check("latency_in_window", longint'((t_valid - t0 >= LATENCY - 1) && (t_valid - t0 <= LATENCY + 1)), 1);
        wait_cycles(20);
        xmit(8'hA3, 1'b1, CPB, 1'b0);
        rx = 1'b1;
        wait_cycles(200);
        check("basic_queue_drained", longint'(exp_q.size()), 0);
        check("basic_frame_err_cnt", fe_cnt, exp_fe);

        rx = 1'b0;
        wait_cycles(20);
        check("glitch_busy_high", longint'(busy), 1);
        wait_cycles(10);
        rx = 1'b1;
        wait_cycles(60);
        check("glitch_busy_low", longint'(busy), 0);
        check("glitch_valid", longint'(valid), 0);

        xmit(8'h0F, 1'b0, CPB, 1'b0);
        wait_cycles(2000);
        check("break_busy_held", longint'(busy), 1);
        check("break_frame_err_cnt", fe_cnt, exp_fe);
        check("break_valid", longint'(valid), 0);
        rx = 1'b1;
        wait_cycles(10);
        check("break_busy_released", longint'(busy), 0);

        ready = 1'b0;
        xmit(8'h11, 1'b1, CPB, 1'b0);
        xmit(8'h22, 1'b1, CPB, 1'b1);
        rx = 1'b1;
        wait_cycles(100);
        check("ovr_valid_held", longint'(valid), 1);
        check("ovr_data_kept", longint'(data), 8'h11);
        check("ovr_count", ov_cnt, exp_ov);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("ovr_valid_cleared", longint'(valid), 0);
        check("ovr_queue_drained", longint'(exp_q.size()), 0);
        ready = 1'b1;
        wait_cycles(50);

        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            wait_cycles(CPB);
        end
        wait_cycles(HALF);
        rst = 1'b1;
        wait_cycles(3);
        check("midrst_busy", longint'(busy), 0);
        rst = 1'b0;
        rx  = 1'b1;
        wait_cycles(2 * CPB);
        check("midrst_valid", longint'(valid), 0);
        xmit(8'h3C, 1'b1, CPB, 1'b0);
        rx = 1'b1;
        wait_cycles(100);
        check("midrst_queue_drained", longint'(exp_q.size()), 0);

        xmit(8'hC6, 1'b1, CPB - 3, 1'b0);
        xmit(8'h39, 1'b1, CPB + 3, 1'b0);
        rx = 1'b1;
        wait_cycles(100);

        for (int n = 0; n < 15; n++) begin
            rb  = 8'($urandom);
            len = CPB - 3 + int'($urandom_range(0, 6));
            bad = ($urandom_range(0, 5) == 0);
            xmit(rb, !bad, len, 1'b0);
            rx  = 1'b1;
            gap = bad ? 10 + int'($urandom_range(0, 40)) : int'($urandom_range(0, 40));
            wait_cycles(gap);
        end

        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick();
        wait_cycles(50);
        check("final_queue_drained", longint'(exp_q.size()), 0);
        check("final_frame_err_cnt", fe_cnt, exp_fe);
        check("final_overrun_cnt", ov_cnt, exp_ov);
        check("final_busy", longint'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
